// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO: registered outputs with atomic SET/CLR, synchronised and
// debounced inputs, edge-detect interrupts with W1C pending bits.
module gpio_ctrl #(
  parameter int          OUT_W     = 16,
  parameter int          IN_W      = 8,
  parameter int          DB_CYCLES = 500000,
  parameter logic [31:0] OUT_RST   = 32'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gpio_en,
  input  logic             w_en,
  input  logic             r_en,
  input  logic [4:0]       addr,
  input  logic [31:0]      din,
  output logic [31:0]      dout,
  output logic             gpio_ready,
  input  logic [IN_W-1:0]  gpio_in,
  output logic [OUT_W-1:0] gpio_out,
  output logic             irq
);

  localparam int CW = (DB_CYCLES > 0) ? $clog2(DB_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((DB_CYCLES > 0) ? DB_CYCLES - 1 : 0);

  localparam logic [2:0] A_DATA_OUT = 3'd0;
  localparam logic [2:0] A_DATA_IN  = 3'd1;
  localparam logic [2:0] A_IRQ_EN   = 3'd2;
  localparam logic [2:0] A_EDGE_SEL = 3'd3;
  localparam logic [2:0] A_IRQ_PEND = 3'd4;
  localparam logic [2:0] A_OUT_SET  = 3'd5;
  localparam logic [2:0] A_OUT_CLR  = 3'd6;

  logic [OUT_W-1:0] out_q, out_d;
  logic [IN_W-1:0]  sync1_q, sync2_q;
  logic [IN_W-1:0]  stable_q, stable_d;
  logic [IN_W-1:0]  stable_dly_q;
  logic [CW-1:0]    cnt_q [IN_W];
  logic [CW-1:0]    cnt_d [IN_W];
  logic [IN_W-1:0]  en_q, en_d;
  logic [IN_W-1:0]  esel_q, esel_d;
  logic [IN_W-1:0]  pend_q, pend_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic [31:0]      dout_q, dout_d;

  logic             req, accept, wr, rd;
  logic [2:0]       sel;
  logic [31:0]      rdata;
  logic [IN_W-1:0]  w1c, rise, fall, set_pend;

  // Debounce: a channel follows sync only after it has differed for DB_CYCLES edges.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < IN_W; i++) begin
      cnt_d[i] = '0;
    end
    if (DB_CYCLES == 0) begin
      stable_d = sync2_q;
    end else begin
      for (int i = 0; i < IN_W; i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
          cnt_d[i]    = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // busy holds off re-acceptance until the master drops its strobe.
  always_comb begin
    req     = gpio_en && (w_en || r_en);
    accept  = req && !ready_q && !busy_q;
    wr      = accept && w_en;
    rd      = accept && r_en && !w_en;
    sel     = addr[4:2];
    ready_d = accept;
    busy_d  = req && (busy_q || accept);

    rdata = 32'h0;
    case (sel)
      A_DATA_OUT: rdata = 32'(out_q);
      A_DATA_IN:  rdata = 32'(stable_q);
      A_IRQ_EN:   rdata = 32'(en_q);
      A_EDGE_SEL: rdata = 32'(esel_q);
      A_IRQ_PEND: rdata = 32'(pend_q);
      default:    rdata = 32'h0;
    endcase
    dout_d = rd ? rdata : 32'h0;

    out_d  = out_q;
    en_d   = en_q;
    esel_d = esel_q;
    w1c    = '0;
    if (wr) begin
      case (sel)
        A_DATA_OUT: out_d  = din[OUT_W-1:0];
        A_IRQ_EN:   en_d   = din[IN_W-1:0];
        A_EDGE_SEL: esel_d = din[IN_W-1:0];
        A_IRQ_PEND: w1c    = din[IN_W-1:0];
        A_OUT_SET:  out_d  = out_q | din[OUT_W-1:0];
        A_OUT_CLR:  out_d  = out_q & ~din[OUT_W-1:0];
        default:    out_d  = out_q;
      endcase
    end

    rise     = stable_q & ~stable_dly_q;
    fall     = ~stable_q & stable_dly_q;
    set_pend = (esel_q & rise) | (~esel_q & fall);
    pend_d   = (pend_q & ~w1c) | set_pend;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= OUT_RST[OUT_W-1:0];
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      for (int i = 0; i < IN_W; i++) begin
        cnt_q[i] <= '0;
      end
      en_q    <= '0;
      esel_q  <= '0;
      pend_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      dout_q  <= 32'h0;
    end else begin
      out_q        <= out_d;
      sync1_q      <= gpio_in;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      for (int i = 0; i < IN_W; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      en_q    <= en_d;
      esel_q  <= esel_d;
      pend_q  <= pend_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      dout_q  <= dout_d;
    end
  end

  assign gpio_out   = out_q;
  assign gpio_ready = ready_q;
  assign dout       = dout_q;
  assign irq        = |(pend_q & en_q);

endmodule
